// File: rtl/fft_8p.sv
// ---------------------------------------------------------------------------
// fft_8p
// Streaming 8-point radix-2 decimation-in-time complex FFT. Samples are
// written into a bit-reversed bank, pushed through three registered
// butterfly stages (each stage halves the result so the final bins are
// X[k]/8) and then read out serially in natural bin order.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   w_en       sample strobe; xr/xi are captured on every edge where high
//   xr, xi     input sample, real / imaginary (signed DW)
//   out_valid  high while yr/yi carry a valid bin
//   out_idx    bin index of the current yr/yi
//   yr, yi     output bin, real / imaginary (signed DW), = X[k]/8
// ---------------------------------------------------------------------------
module fft_8p #(
    parameter int DW = 16,
    parameter int TW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 w_en,
    input  logic signed [DW-1:0] xr,
    input  logic signed [DW-1:0] xi,
    output logic                 out_valid,
    output logic [2:0]           out_idx,
    output logic signed [DW-1:0] yr,
    output logic signed [DW-1:0] yi
);

    // Butterfly sums are carried two bits wider than the data so a + t
    // never wraps before the halving shift and saturation.
    localparam int SW = DW + 2;

    // cos(pi/4) in Q1.15; W1 and W3 only differ from it by signs.
    localparam logic signed [TW-1:0] W_C45 = TW'(23170);

    localparam logic signed [SW-1:0] SAT_MAX = SW'((1 <<< (DW - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

    // Capture side
    logic [2:0]           r_wcnt;
    logic                 r_launch;
    logic signed [DW-1:0] r_xr [8];
    logic signed [DW-1:0] r_xi [8];

    // Stage banks and their valid flags
    logic                 r_v1, r_v2, r_v3;
    logic signed [DW-1:0] r_s1r [8];
    logic signed [DW-1:0] r_s1i [8];
    logic signed [DW-1:0] r_s2r [8];
    logic signed [DW-1:0] r_s2i [8];
    logic signed [DW-1:0] r_s3r [8];
    logic signed [DW-1:0] r_s3i [8];

    // Combinational next values of each stage bank
    logic signed [DW-1:0] w_s1r [8];
    logic signed [DW-1:0] w_s1i [8];
    logic signed [DW-1:0] w_s2r [8];
    logic signed [DW-1:0] w_s2i [8];
    logic signed [DW-1:0] w_s3r [8];
    logic signed [DW-1:0] w_s3i [8];

    logic [2:0] w_wadr;
    logic [2:0] w_nidx;

    // Multiply a widened sum by cos(pi/4) with a 32-bit product and drop
    // the 15 fractional bits (floor, since >>> on a signed value).
    function automatic logic signed [SW-1:0] mulC(input logic signed [SW-1:0] s);
        logic signed [31:0] p;
        p = 32'(W_C45) * 32'(s);
        p = p >>> 15;
        return p[SW-1:0];
    endfunction

    // Halve a widened sum and clamp it into the DW-bit output range.
    function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] h;
        h = s >>> 1;
        if (h > SAT_MAX)      return SAT_MAX[DW-1:0];
        else if (h < SAT_MIN) return SAT_MIN[DW-1:0];
        else                  return h[DW-1:0];
    endfunction

    // One scaled butterfly with twiddle W8^k. W0 is a bypass and W2 (-j) is
    // a swap/negate, so only W1 and W3 use the multiplier. Returns
    // {A're, A'im, B're, B'im}.
    function automatic logic [4*DW-1:0] bfly(
        input logic signed [DW-1:0] ar,
        input logic signed [DW-1:0] ai,
        input logic signed [DW-1:0] br,
        input logic signed [DW-1:0] bi,
        input logic [1:0]           k
    );
        logic signed [SW-1:0] ear, eai, ebr, ebi, tr, ti;
        ear = SW'(ar);
        eai = SW'(ai);
        ebr = SW'(br);
        ebi = SW'(bi);
        case (k)
            2'd0: begin
                tr = ebr;
                ti = ebi;
            end
            2'd1: begin
                tr = mulC(ebr + ebi);
                ti = mulC(ebi - ebr);
            end
            2'd2: begin
                tr = ebi;
                ti = -ebr;
            end
            default: begin
                tr = mulC(ebi - ebr);
                ti = mulC(-(ebr + ebi));
            end
        endcase
        return {sat(ear + tr), sat(eai + ti), sat(ear - tr), sat(eai - ti)};
    endfunction

    // Bit-reversing the write address lets the DIT stages work in place
    // and leaves the final bank in natural bin order.
    assign w_wadr = {r_wcnt[0], r_wcnt[1], r_wcnt[2]};
    assign w_nidx = out_idx + 3'd1;

    // Sample capture: the write counter only advances on accepted samples,
    // so gaps in w_en simply stretch the frame. The edge that writes the
    // eighth sample raises the launch flag for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt   <= '0;
            r_launch <= 1'b0;
            for (int n = 0; n < 8; n++) begin
                r_xr[n] <= '0;
                r_xi[n] <= '0;
            end
        end else begin
            r_launch <= w_en && (r_wcnt == 3'd7);
            if (w_en) begin
                r_wcnt       <= r_wcnt + 3'd1;
                r_xr[w_wadr] <= xr;
                r_xi[w_wadr] <= xi;
            end
        end
    end

    // Stage 1: span-1 butterflies, all twiddles W0.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            {w_s1r[2*b], w_s1i[2*b], w_s1r[2*b+1], w_s1i[2*b+1]} =
                bfly(r_xr[2*b], r_xi[2*b], r_xr[2*b+1], r_xi[2*b+1], 2'd0);
        end
    end

    // Stage 2: span-2 butterflies; the second pair of each quad uses W2.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            {w_s2r[(b/2)*4 + b%2], w_s2i[(b/2)*4 + b%2],
             w_s2r[(b/2)*4 + b%2 + 2], w_s2i[(b/2)*4 + b%2 + 2]} =
                bfly(r_s1r[(b/2)*4 + b%2], r_s1i[(b/2)*4 + b%2],
                     r_s1r[(b/2)*4 + b%2 + 2], r_s1i[(b/2)*4 + b%2 + 2],
                     2'((b % 2) * 2));
        end
    end

    // Stage 3: span-4 butterflies with twiddles W0..W3.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            {w_s3r[b], w_s3i[b], w_s3r[b+4], w_s3i[b+4]} =
                bfly(r_s2r[b], r_s2i[b], r_s2r[b+4], r_s2i[b+4], 2'(b));
        end
    end

    // Stage banks: each loads only when the flag from the stage above is
    // set, so a frame advances exactly one stage per clock and a bank keeps
    // its contents while no new frame is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
            for (int n = 0; n < 8; n++) begin
                r_s1r[n] <= '0;
                r_s1i[n] <= '0;
                r_s2r[n] <= '0;
                r_s2i[n] <= '0;
                r_s3r[n] <= '0;
                r_s3i[n] <= '0;
            end
        end else begin
            r_v1 <= r_launch;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            if (r_launch) begin
                r_s1r <= w_s1r;
                r_s1i <= w_s1i;
            end
            if (r_v1) begin
                r_s2r <= w_s2r;
                r_s2i <= w_s2i;
            end
            if (r_v2) begin
                r_s3r <= w_s3r;
                r_s3i <= w_s3i;
            end
        end
    end

    // Output serializer: a freshly loaded stage-3 bank restarts at bin 0;
    // otherwise an active burst steps through bins 1..7 and then goes idle.
    // Because the bank is read before it is overwritten, the last bin of a
    // frame is still correct when the next frame lands on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            yr        <= '0;
            yi        <= '0;
        end else if (r_v3) begin
            out_valid <= 1'b1;
            out_idx   <= '0;
            yr        <= r_s3r[0];
            yi        <= r_s3i[0];
        end else if (out_valid && (out_idx != 3'd7)) begin
            out_idx   <= w_nidx;
            yr        <= r_s3r[w_nidx];
            yi        <= r_s3i[w_nidx];
        end else begin
            out_valid <= 1'b0;
            out_idx   <= '0;
        end
    end

endmodule

// File: tb/tb_fft_8p.sv
// ---------------------------------------------------------------------------
// tb_fft_8p
// Directed bench for fft_8p. Each frame sent pushes its hand-computed bins,
// tagged with the cycle they must appear on, into a scoreboard queue; an
// independent monitor pops and compares whenever out_valid is high.
// ---------------------------------------------------------------------------
module tb_fft_8p;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               w_en;
    logic signed [15:0] xr;
    logic signed [15:0] xi;
    logic               out_valid;
    logic [2:0]         out_idx;
    logic signed [15:0] yr;
    logic signed [15:0] yi;

    typedef struct {
        int cycle;
        int idx;
        int re;
        int im;
        int tol;
    } exp_t;

    exp_t sbQ[$];
    int   nChecks = 0;
    int   nFails  = 0;
    int   cyc     = 0;
    int   lastCyc = 0;

    int zero8[8]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    int impX[8]   = '{8000, 0, 0, 0, 0, 0, 0, 0};
    int impYr[8]  = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
    int dcX[8]    = '{8000, 8000, 8000, 8000, 8000, 8000, 8000, 8000};
    int dcYr[8]   = '{8000, 0, 0, 0, 0, 0, 0, 0};
    int sinX[8]   = '{0, 23170, 32767, 23170, 0, -23170, -32767, -23170};
    int sinYi[8]  = '{0, -16384, 0, 0, 0, 0, 0, 16384};

    fft_8p #(.DW(16), .TW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .w_en      (w_en),
        .xr        (xr),
        .xi        (xi),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .yr        (yr),
        .yi        (yi)
    );

    // Free-running clock and a count of rising edges so far.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every valid output must match the oldest expected bin,
    // including the exact cycle it was due on.
    always @(negedge clk) begin
        exp_t e;
        int   dr, di;
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            nChecks++;
            if (sbQ.size() == 0) begin
                nFails++;
                $display("[TB] FAIL unexpected_output: got idx=%0d yr=%0d yi=%0d at cycle %0d, required no output",
                         out_idx, yr, yi, cyc);
            end else begin
                e  = sbQ.pop_front();
                dr = int'(yr) - e.re;
                di = int'(yi) - e.im;
                if (dr < 0) dr = -dr;
                if (di < 0) di = -di;
                if (cyc != e.cycle || int'(out_idx) != e.idx || dr > e.tol || di > e.tol) begin
                    nFails++;
                    $display("[TB] FAIL bin%0d: got idx=%0d yr=%0d yi=%0d cycle=%0d, required idx=%0d yr=%0d yi=%0d (tol %0d) cycle=%0d",
                             e.idx, out_idx, yr, yi, cyc, e.idx, e.re, e.im, e.tol, e.cycle);
                end
            end
        end
    end

    // Watchdog so the run always ends even if something stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish by 200000, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one accepted sample on the next falling edge.
    task automatic applyStimulus(input int r, input int i);
        @(negedge clk);
        w_en    = 1'b1;
        xr      = 16'(r);
        xi      = 16'(i);
        lastCyc = cyc;
    endtask

    // Leave w_en low for n edges with junk on the data inputs.
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            w_en = 1'b0;
            xr   = 16'sh1234;
            xi   = -16'sh0567;
        end
    endtask

    // Send eight samples, optionally pausing for gapLen edges after sample gapAfter.
    task automatic sendFrame(input int fr[8], input int fi[8], input int gapAfter, input int gapLen);
        for (int n = 0; n < 8; n++) begin
            applyStimulus(fr[n], fi[n]);
            if (n == gapAfter) idle(gapLen);
        end
    endtask

    // Bin 0 is due four edges after the edge that took the last sample.
    task automatic expectFrame(input int er[8], input int ei[8], input int tol);
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            e.cycle = lastCyc + 5 + k;
            e.idx   = k;
            e.re    = er[k];
            e.im    = ei[k];
            e.tol   = tol;
            sbQ.push_back(e);
        end
    endtask

    task automatic checkOutput(input string name, input int actual, input int required);
        nChecks++;
        if (actual != required) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    // Directed sequence: reset, discarded partial frame, impulse, DC, sine,
    // gapped impulse, back-to-back frames with a reset mid-output, recovery.
    initial begin
        rst_n = 1'b0;
        w_en  = 1'b0;
        xr    = '0;
        xi    = '0;

        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            w_en = n[0];
            xr   = 16'(1000 * (n + 1));
            xi   = 16'(-300 * n);
            @(posedge clk);
            #1;
            checkOutput("reset_out_valid", int'(out_valid), 0);
            checkOutput("reset_yr", int'(yr), 0);
            checkOutput("reset_yi", int'(yi), 0);
        end
        checkOutput("reset_out_idx", int'(out_idx), 0);

        @(negedge clk);
        w_en  = 1'b0;
        rst_n = 1'b1;
        idle(10);

        for (int n = 0; n < 5; n++) applyStimulus(4000 + n, 77);
        idle(12);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(3);

        $display("[TB] impulse frame");
        sendFrame(impX, zero8, -1, 0);
        expectFrame(impYr, zero8, 0);
        idle(14);

        $display("[TB] DC frame");
        sendFrame(dcX, zero8, -1, 0);
        expectFrame(dcYr, zero8, 0);
        idle(14);

        $display("[TB] sine frame after fresh reset");
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        sendFrame(sinX, zero8, -1, 0);
        expectFrame(zero8, sinYi, 4);
        idle(14);

        $display("[TB] gapped impulse frame");
        sendFrame(impX, zero8, 3, 3);
        expectFrame(impYr, zero8, 0);
        idle(14);

        $display("[TB] back-to-back impulse then DC");
        sendFrame(impX, zero8, -1, 0);
        expectFrame(impYr, zero8, 0);
        sendFrame(dcX, zero8, -1, 0);
        expectFrame(dcYr, zero8, 0);
        idle(8);
        @(posedge clk);
        #1;
        checkOutput("midout_valid_before_reset", int'(out_valid), 1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midout_valid_after_reset", int'(out_valid), 0);
        checkOutput("midout_yr_after_reset", int'(yr), 0);
        checkOutput("midout_yi_after_reset", int'(yi), 0);
        checkOutput("midout_idx_after_reset", int'(out_idx), 0);
        sbQ.delete();
        idle(2);
        rst_n = 1'b1;
        idle(10);

        $display("[TB] recovery DC frame");
        sendFrame(dcX, zero8, -1, 0);
        expectFrame(dcYr, zero8, 0);
        idle(1);
        for (int t = 0; t < 40 && sbQ.size() != 0; t++) @(negedge clk);
        checkOutput("scoreboard_drained", sbQ.size(), 0);
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
